// File: rtl/simon_game_ctrl_if.sv
// Player-facing bus of the Simon game controller: start/button inputs in,
// display control and score/status out.
interface simon_game_ctrl_if #(
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic          start;
    logic [3:0]    btn;
    logic          disp_en;
    logic [1:0]    disp_color;
    logic [LW-1:0] level;
    logic          game_over;
    logic          win;

    modport master (
        output start, btn,
        input  disp_en, disp_color, level, game_over, win
    );

    modport slave (
        input  start, btn,
        output disp_en, disp_color, level, game_over, win
    );
endinterface

// File: rtl/simon_game_ctrl.sv
// Simon game controller: grows an LFSR-derived colour sequence, flashes it on
// the VGA stage and checks the player's presses step by step.
module simon_game_ctrl #(
    parameter int          ON_CYCLES      = 12500000,
    parameter int          GAP_CYCLES     = 6250000,
    parameter int          TIMEOUT_CYCLES = 150000000,
    parameter int          MAX_LEN        = 16,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    simon_game_ctrl_if.slave bus
);
    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX = (TIMEOUT_CYCLES > ON_CYCLES)
                        ? ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES)
                        : ((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE, SHOW_ON, SHOW_GAP, WAIT_IN, ECHO_ON, ECHO_GAP, LOSE, WIN
    } state_t;

    state_t        state, state_n;
    logic [15:0]   lfsr;
    logic [TW-1:0] timer, timer_n;
    logic [IW-1:0] idx, idx_n;
    logic [LW-1:0] level, level_n;
    logic [1:0]    color, color_n;
    logic [1:0]    seq [MAX_LEN];
    logic          append;
    logic [IW-1:0] append_addr;
    logic          press_one;
    logic [1:0]    press_color;
    logic          idx_last;
    logic          disp_en, game_over, win;

    always_comb begin
        press_one   = 1'b1;
        press_color = 2'd0;
        case (bus.btn)
            4'b0001: press_color = 2'd0;
            4'b0010: press_color = 2'd1;
            4'b0100: press_color = 2'd2;
            4'b1000: press_color = 2'd3;
            default: press_one   = 1'b0;
        endcase
    end

    assign idx_last = ((LW'(idx) + LW'(1)) == level);

    always_comb begin
        state_n     = state;
        timer_n     = timer + TW'(1);
        idx_n       = idx;
        level_n     = level;
        color_n     = color;
        append      = 1'b0;
        append_addr = level[IW-1:0];
        case (state)
            IDLE, LOSE, WIN: begin
                timer_n = '0;
                if (bus.start) begin
                    level_n     = LW'(1);
                    idx_n       = '0;
                    append      = 1'b1;
                    append_addr = '0;
                    color_n     = lfsr[1:0];
                    state_n     = SHOW_ON;
                end
            end
            SHOW_ON: begin
                if (timer == TW'(ON_CYCLES - 1)) begin
                    timer_n = '0;
                    state_n = SHOW_GAP;
                end
            end
            SHOW_GAP: begin
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    timer_n = '0;
                    if (idx_last) begin
                        idx_n   = '0;
                        state_n = WAIT_IN;
                    end else begin
                        idx_n   = idx + IW'(1);
                        color_n = seq[idx_n];
                        state_n = SHOW_ON;
                    end
                end
            end
            WAIT_IN: begin
                // A press in the final idle cycle still beats the timeout
                if (bus.btn == 4'b0000) begin
                    if (timer == TW'(TIMEOUT_CYCLES - 1))
                        state_n = LOSE;
                end else if (press_one && (press_color == seq[idx])) begin
                    timer_n = '0;
                    color_n = press_color;
                    state_n = ECHO_ON;
                end else begin
                    state_n = LOSE;
                end
            end
            ECHO_ON: begin
                if (timer == TW'(ON_CYCLES - 1)) begin
                    timer_n = '0;
                    state_n = ECHO_GAP;
                end
            end
            ECHO_GAP: begin
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    timer_n = '0;
                    if (!idx_last) begin
                        idx_n   = idx + IW'(1);
                        state_n = WAIT_IN;
                    end else if (level == LW'(MAX_LEN)) begin
                        state_n = WIN;
                    end else begin
                        append  = 1'b1;
                        level_n = level + LW'(1);
                        idx_n   = '0;
                        color_n = seq[0];
                        state_n = SHOW_ON;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED;
            timer     <= '0;
            idx       <= '0;
            level     <= '0;
            color     <= 2'd0;
            disp_en   <= 1'b0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            state     <= state_n;
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            timer     <= timer_n;
            idx       <= idx_n;
            level     <= level_n;
            color     <= color_n;
            disp_en   <= (state_n == SHOW_ON) || (state_n == ECHO_ON);
            game_over <= (state_n == LOSE);
            win       <= (state_n == WIN);
        end
    end

    // Sequence memory survives start; entries are only ever overwritten by appends
    always_ff @(posedge clk) begin
        if (!rst && append)
            seq[append_addr] <= lfsr[1:0];
    end

    assign bus.disp_en    = disp_en;
    assign bus.disp_color = color;
    assign bus.level      = level;
    assign bus.game_over  = game_over;
    assign bus.win        = win;
endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed-random bench for simon_game_ctrl: the expected colour sequence is
// rebuilt from an LFSR model and the visible flashes are timed cycle by cycle.
module tb_simon_game_ctrl;
    localparam int          ON   = 4;
    localparam int          GAP  = 2;
    localparam int          TO   = 20;
    localparam int          ML   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] lfsr_m;
    logic [1:0]  q[$];

    simon_game_ctrl_if #(.MAX_LEN(ML)) bus();

    simon_game_ctrl #(
        .ON_CYCLES(ON), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO),
        .MAX_LEN(ML), .SEED(SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Taps 16,14,13,11 feed the new LSB of a left-shifting register
    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return {v[14:0], v[16-1] ^ v[14-1] ^ v[13-1] ^ v[11-1]};
    endfunction

    always @(posedge clk) lfsr_m <= rst ? SEED : lfsrNext(lfsr_m);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [3:0] b);
        bus.start = st;
        bus.btn   = b;
        tick();
        bus.start = 1'b0;
        bus.btn   = 4'b0000;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " disp_en"},    32'(bus.disp_en),    0);
        checkOutput({tag, " disp_color"}, 32'(bus.disp_color), 0);
        checkOutput({tag, " level"},      32'(bus.level),      0);
        checkOutput({tag, " game_over"},  32'(bus.game_over),  0);
        checkOutput({tag, " win"},        32'(bus.win),        0);
    endtask

    // Waits for disp_en to rise, then measures one flash until it falls
    task automatic waitFlash(input string tag, input logic [1:0] exp_color,
                             output int waited, output logic [15:0] rise_lfsr);
        int   len;
        logic [1:0] col;
        logic stable;
        waited    = 0;
        rise_lfsr = lfsr_m;
        while (bus.disp_en !== 1'b1 && waited < 50) begin
            rise_lfsr = lfsr_m;
            tick();
            waited++;
        end
        checkOutput({tag, " rise"}, 32'(waited < 50), 1);
        col    = bus.disp_color;
        stable = 1'b1;
        len    = 0;
        while (bus.disp_en === 1'b1 && len < 50) begin
            if (bus.disp_color !== col) stable = 1'b0;
            tick();
            len++;
        end
        checkOutput({tag, " color"},  32'(col),    32'(exp_color));
        checkOutput({tag, " stable"}, 32'(stable), 1);
        checkOutput({tag, " len"},    len,         ON);
    endtask

    task automatic playback(input string tag, input bit after_round);
        int w;
        logic [15:0] rl;
        for (int i = 0; i < q.size(); i++) begin
            waitFlash(tag, q[i], w, rl);
            if (i == 0 && after_round) begin
                q.push_back(rl[1:0]);
                checkOutput({tag, " level"}, 32'(bus.level), q.size());
            end
            checkOutput({tag, " gap"}, w, (i == 0 && !after_round) ? 0 : GAP);
        end
        repeat (GAP) tick();
        checkOutput({tag, " quiet"}, 32'(bus.disp_en), 0);
    endtask

    task automatic startGame(input string tag);
        logic [15:0] l;
        l = lfsr_m;
        applyStimulus(1'b1, 4'b0000);
        q.delete();
        q.push_back(l[1:0]);
        checkOutput({tag, " level"},     32'(bus.level),     1);
        checkOutput({tag, " game_over"}, 32'(bus.game_over), 0);
        checkOutput({tag, " win"},       32'(bus.win),       0);
        playback(tag, 1'b0);
    endtask

    task automatic pressEcho(input string tag, input logic [1:0] c);
        int w;
        logic [15:0] rl;
        applyStimulus(1'b0, 4'b0001 << c);
        waitFlash({tag, " echo"}, c, w, rl);
        checkOutput({tag, " echo_delay"}, w, 0);
    endtask

    // Plays the whole current sequence correctly; first_delay < 0 means random
    task automatic playRound(input string tag, input int first_delay);
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) begin
            int d;
            d = (i == 0 && first_delay >= 0) ? first_delay : int'($urandom_range(0, 5));
            repeat (d) tick();
            checkOutput({tag, " alive"}, 32'(bus.game_over), 0);
            pressEcho(tag, q[i]);
            if (i < n - 1) repeat (GAP) tick();
        end
        if (n == ML) begin
            repeat (GAP - 1) tick();
            checkOutput({tag, " win_early"}, 32'(bus.win), 0);
            tick();
            checkOutput({tag, " win"},       32'(bus.win),       1);
            checkOutput({tag, " win_level"}, 32'(bus.level),     ML);
            checkOutput({tag, " win_en"},    32'(bus.disp_en),   0);
            checkOutput({tag, " win_go"},    32'(bus.game_over), 0);
        end else begin
            playback({tag, " replay"}, 1'b1);
        end
    endtask

    initial begin
        logic [1:0]  bad;
        logic [15:0] l;
        bus.start = 1'b0;
        bus.btn   = 4'b0000;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checkReset("reset");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'($urandom_range(1, 15)));
        checkReset("idle_btn");

        repeat ($urandom_range(0, 7)) tick();
        startGame("start1");
        playRound("round1", -1);

        bad = q[0] + 2'($urandom_range(1, 3));
        applyStimulus(1'b0, 4'b0001 << bad);
        checkOutput("wrong game_over", 32'(bus.game_over), 1);
        checkOutput("wrong disp_en",   32'(bus.disp_en),   0);
        checkOutput("wrong level",     32'(bus.level),     2);

        repeat ($urandom_range(0, 5)) tick();
        startGame("start2");
        applyStimulus(1'b0, 4'b0011);
        checkOutput("multi game_over", 32'(bus.game_over), 1);
        checkOutput("multi disp_en",   32'(bus.disp_en),   0);
        checkOutput("multi level",     32'(bus.level),     1);

        startGame("start3");
        repeat (TO - 1) tick();
        checkOutput("timeout early", 32'(bus.game_over), 0);
        tick();
        checkOutput("timeout game_over", 32'(bus.game_over), 1);
        checkOutput("timeout level",     32'(bus.level),     1);

        repeat ($urandom_range(0, 5)) tick();
        startGame("start4");
        playRound("win_r1", TO - 1);
        playRound("win_r2", -1);
        playRound("win_r3", -1);

        l = lfsr_m;
        applyStimulus(1'b1, 4'b0000);
        checkOutput("restart win",   32'(bus.win),        0);
        checkOutput("restart level", 32'(bus.level),      1);
        checkOutput("restart en",    32'(bus.disp_en),    1);
        checkOutput("restart color", 32'(bus.disp_color), 32'(l[1:0]));
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checkReset("rst_show");
        rst = 1'b0;
        tick();
        checkReset("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/simon_game_ctrl.md
Name: simon_game_ctrl

Overview:
- Game controller for the Simon Says design.
- Builds a pseudo-random colour sequence and plays it back one step per flash, then checks the player's button presses against it.
- Sits directly upstream of the VGA display stage and drives that stage's en/color inputs.
- Button inputs arrive already debounced and pulse-shaped.

Parameters:
- ON_CYCLES, 12500000, clock cycles a colour stays displayed (playback flash and press echo).
- GAP_CYCLES, 6250000, clock cycles of blank display after each flash.
- TIMEOUT_CYCLES, 150000000, maximum clock cycles allowed between player presses.
- MAX_LEN, 16, sequence length that wins the game.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse that begins a new game.
- btn, input, 4, one-cycle press pulses; bit0 red, bit1 green, bit2 blue, bit3 cyan.
- disp_en, output, 1, display single-colour mode; drives VGA en.
- disp_color, output, 2, colour code: 00 red, 01 green, 10 blue, 11 cyan; drives VGA color.
- level, output, $clog2(MAX_LEN+1), current sequence length (score).
- game_over, output, 1, high while in LOSE.
- win, output, 1, high while in WIN.

Behaviour:
- Reset: state IDLE; disp_en=0, disp_color=00, level=0, game_over=0, win=0; lfsr=SEED; idx=0; timer=0. Reset overrides everything, including mid-playback.
- All outputs are registered and change only on clk edges.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle out of reset. An append stores lfsr[1:0] into seq[level] and increments level.
- States are IDLE, SHOW_ON, SHOW_GAP, WAIT_IN, ECHO_ON, ECHO_GAP, LOSE, WIN.
- start:
  - Honoured only in IDLE, LOSE and WIN; ignored elsewhere.
  - Clears game_over and win, sets level=0, then appends once (level=1), idx=0, enters SHOW_ON.
- SHOW_ON:
  - disp_en=1, disp_color=seq[idx], held exactly ON_CYCLES cycles.
  - disp_en first reads 1 in the cycle after start (or after the previous gap) is sampled.
  - Then enters SHOW_GAP.
- SHOW_GAP:
  - disp_en=0 for GAP_CYCLES cycles, then idx++.
  - If idx == level, sets idx=0, clears the timeout timer and enters WAIT_IN; otherwise returns to SHOW_ON.
- WAIT_IN:
  - disp_en=0.
  - btn==0: timer counts; reaching TIMEOUT_CYCLES enters LOSE.
  - Exactly one bit set: encode to colour c.
    - c != seq[idx]: enter LOSE the next cycle.
    - c == seq[idx]: enter ECHO_ON with disp_color=c.
  - More than one bit set: treated as a wrong press, enters LOSE.
- ECHO_ON:
  - disp_en=1 for ON_CYCLES cycles, then ECHO_GAP (disp_en=0, GAP_CYCLES cycles).
  - After ECHO_GAP:
    - If idx < level-1: idx++, timer cleared, return to WAIT_IN.
    - Else (round complete), if level == MAX_LEN: enter WIN.
    - Else (round complete, level < MAX_LEN): append, idx=0, enter SHOW_ON.
- btn pulses in every state except WAIT_IN are ignored and not queued.
- LOSE: disp_en=0, game_over=1, level frozen; waits for start.
- WIN: disp_en=0, win=1, level=MAX_LEN; waits for start.
- disp_color holds its last value whenever disp_en=0.
- level never exceeds MAX_LEN.
- seq storage is MAX_LEN x 2-bit registers; it is not cleared by start, only overwritten on append.

Test Plan (overrides ON_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20, MAX_LEN=3):
- Reset: hold rst high 3 cycles, release -> disp_en=0, disp_color=00, level=0, game_over=0, win=0; btn pulses in IDLE leave these unchanged.
- Start/playback: start pulse -> level=1 next cycle; disp_en=1 for exactly 4 cycles with disp_color equal to the bench LFSR model's lfsr[1:0] at start; then disp_en=0; no further flash.
- Correct round: press the matching btn one-hot -> echo 4 cycles high; 2-cycle gap; replay of 2 flashes (seq[0] then seq[1], each 4 on / 2 off); level=2.
- Wrong/multi press: in WAIT_IN press a non-matching bit -> game_over=1 the next cycle, disp_en=0, level holds. Repeat with btn=4'b0011 -> same result.
- Timeout: no press for 20 cycles in WAIT_IN -> game_over=1. A press at cycle 19 -> no LOSE.
- Win/restart: play all 3 rounds correctly -> win=1, level=3. Then start -> win=0, level=1, new playback. Assert rst during SHOW_ON -> all outputs return to reset values the next cycle.
